// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, redirect and data-memory-wait stall/flush generation.
// Latency: stall/flush outputs are combinational (Mealy). mem_fault and stall_count are registered.
// Backpressure: a dmem wait freezes PC..EX/MEM. A watchdog latches FAULT after MAX_WAIT+1 frozen cycles.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ID_*/EX_* hazard inputs         operand usage of the ID and EX instructions
//   MEM_req, dmem_ack               data-memory handshake for the MEM-stage instruction
//   fault_clr, perf_clr             synchronous clears of the FAULT state and the stall counter
//   *_stall / *_flush               per-stage hold and bubble controls
//   mem_fault, stall_count          watchdog status and saturating PC-stall cycle count
module hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic [2:0]  ID_ValidReg,
    input  logic        ID_MemWrite,
    input  logic [4:0]  EX_rd,
    input  logic [2:0]  EX_ValidReg,
    input  logic        EX_MemRead,
    input  logic        EX_redirect,
    input  logic        MEM_req,
    input  logic        dmem_ack,
    input  logic        fault_clr,
    input  logic        perf_clr,
    output logic        PC_stall,
    output logic        IF_ID_stall,
    output logic        ID_EX_stall,
    output logic        EX_MEM_stall,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        MEM_WB_flush,
    output logic        mem_fault,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic load_use;
    logic freeze;

    // A store's rs2 is bypassed on the MEM side, so only its rs1 can create a load-use stall.
    always_comb begin
        load_use = EX_MemRead && EX_ValidReg[0] && (EX_rd != 5'd0) &&
                   ((ID_ValidReg[1] && (ID_rs1 == EX_rd)) ||
                    (ID_ValidReg[2] && (ID_rs2 == EX_rd) && !ID_MemWrite));
    end

    always_comb begin
        freeze = 1'b0;
        case (state_q)
            RUN:      freeze = MEM_req && !dmem_ack;
            MEM_WAIT: freeze = !dmem_ack;
            FAULT:    freeze = 1'b1;
            default:  freeze = 1'b0;
        endcase
    end

    // Outputs are gated by rst_n so the pipeline sees no hold/bubble while reset is applied.
    always_comb begin
        PC_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        ID_EX_stall  = 1'b0;
        EX_MEM_stall = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        MEM_WB_flush = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                // EX does not advance, so any redirect or load-use waits for the freeze to end.
                PC_stall     = 1'b1;
                IF_ID_stall  = 1'b1;
                ID_EX_stall  = 1'b1;
                EX_MEM_stall = 1'b1;
                MEM_WB_flush = 1'b1;
            end else if (EX_redirect) begin
                IF_ID_flush  = 1'b1;
                ID_EX_flush  = 1'b1;
            end else if (load_use) begin
                PC_stall     = 1'b1;
                IF_ID_stall  = 1'b1;
                ID_EX_flush  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (MEM_req && !dmem_ack) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == 8'(MAX_WAIT)) begin
                    state_d    = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (perf_clr) begin
            stall_count_d = 32'd0;
        end else if (PC_stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign mem_fault   = (state_q == FAULT);
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int unsigned MAX_W = 4;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] id_vr;
        logic       id_mw;
        logic [4:0] ex_rd;
        logic [2:0] ex_vr;
        logic       ex_mr;
        logic       redir;
        logic       req;
        logic       ack;
        logic       fclr;
        logic       pclr;
    } stim_t;

    // ctl = {PC, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush, ID_EX_flush, MEM_WB_flush}
    typedef struct packed {
        logic [6:0]  ctl;
        logic        fault;
        logic [31:0] count;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
    logic [2:0]  ID_ValidReg = '0, EX_ValidReg = '0;
    logic        ID_MemWrite = 1'b0, EX_MemRead = 1'b0, EX_redirect = 1'b0;
    logic        MEM_req = 1'b0, dmem_ack = 1'b0, fault_clr = 1'b0, perf_clr = 1'b0;
    logic        PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall;
    logic        IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_fault;
    logic [31:0] stall_count;

    hazard_ctrl #(.MAX_WAIT(MAX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_ValidReg(ID_ValidReg), .ID_MemWrite(ID_MemWrite),
        .EX_rd(EX_rd), .EX_ValidReg(EX_ValidReg), .EX_MemRead(EX_MemRead), .EX_redirect(EX_redirect),
        .MEM_req(MEM_req), .dmem_ack(dmem_ack), .fault_clr(fault_clr), .perf_clr(perf_clr),
        .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
        .EX_MEM_stall(EX_MEM_stall), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .MEM_WB_flush(MEM_WB_flush), .mem_fault(mem_fault), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    // Reference model: watchdog tracked as a run length of consecutive frozen cycles.
    bit              m_fault = 1'b0;
    bit              m_wait = 1'b0;
    int              m_run = 0;
    longint unsigned m_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, want);
        end
    endtask

    // Monitor: compares every presented cycle against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ctl", {25'd0, PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
                              IF_ID_flush, ID_EX_flush, MEM_WB_flush}, {25'd0, e.ctl});
                check("mem_fault", {31'd0, mem_fault}, {31'd0, e.fault});
                check("stall_count", stall_count, e.count);
            end
        end
    end

    task automatic step(input stim_t s, input bit preload = 1'b0);
        exp_t e;
        bit   lu, frz;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = s.rst_n; ID_rs1 = s.rs1; ID_rs2 = s.rs2; ID_ValidReg = s.id_vr;
        ID_MemWrite = s.id_mw; EX_rd = s.ex_rd; EX_ValidReg = s.ex_vr; EX_MemRead = s.ex_mr;
        EX_redirect = s.redir; MEM_req = s.req; dmem_ack = s.ack;
        fault_clr = s.fclr; perf_clr = s.pclr;
        if (preload) begin
            force dut.stall_count_q = 32'hFFFF_FFFD;
            m_cnt = 64'hFFFF_FFFD;
        end
        e = '0;
        if (!s.rst_n) begin
            m_fault = 1'b0; m_wait = 1'b0; m_run = 0; m_cnt = 0;
        end else begin
            lu  = s.ex_mr && s.ex_vr[0] && (s.ex_rd != 0) &&
                  ((s.id_vr[1] && s.rs1 == s.ex_rd) ||
                   (s.id_vr[2] && s.rs2 == s.ex_rd && !s.id_mw));
            frz = m_fault || ((s.req || m_wait) && !s.ack);
            if (frz)          e.ctl = 7'b1111_001;
            else if (s.redir) e.ctl = 7'b0000_110;
            else if (lu)      e.ctl = 7'b1100_010;
            e.fault = m_fault;
            e.count = m_cnt[31:0];
            if (m_fault) begin
                if (s.fclr) begin m_fault = 1'b0; m_run = 0; end
            end else if (frz) begin
                m_run++;
                if (m_run == MAX_W + 1) begin m_fault = 1'b1; m_wait = 1'b0; end
                else m_wait = 1'b1;
            end else begin
                m_wait = 1'b0; m_run = 0;
            end
            if (s.pclr) m_cnt = 0;
            else if (e.ctl[6] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
        sb.push_back(e);
        if (preload) begin
            #1;
            release dut.stall_count_q;
        end
    endtask

    initial begin
        stim_t s;
        s = '0;
        step(s); step(s);
        s.rst_n = 1'b1;
        step(s);
        // load-use on rs1, then load leaves EX, then x0
        s.ex_mr = 1; s.ex_rd = 5; s.ex_vr = 3'b001; s.id_vr = 3'b011; s.rs1 = 5;
        step(s);
        s.ex_mr = 0; step(s);
        s.ex_mr = 1; s.ex_rd = 0; s.rs1 = 0; step(s);
        // store rs2 exempt; store rs1 stalls
        s.ex_rd = 5; s.rs1 = 1; s.rs2 = 5; s.id_vr = 3'b100; s.id_mw = 1; step(s);
        s.rs1 = 5; s.rs2 = 2; s.id_vr = 3'b110; step(s);
        s.ex_mr = 0; s.id_mw = 0; step(s);
        // three wait states with a redirect held throughout
        s.req = 1; s.redir = 1;
        repeat (3) step(s);
        s.ack = 1; step(s);
        s.req = 0; s.ack = 0; s.redir = 0; step(s);
        // redirect beats load-use
        s.ex_mr = 1; s.ex_rd = 5; s.rs1 = 5; s.id_vr = 3'b011; s.redir = 1; step(s);
        s.ex_mr = 0; s.redir = 0;
        // watchdog: trip, ignore ack in FAULT, then clear
        s.req = 1; repeat (7) step(s);
        s.ack = 1; repeat (2) step(s);
        s.req = 0; s.ack = 0; s.fclr = 1; step(s);
        s.fclr = 0; step(s);
        // reset mid-wait
        s.req = 1; repeat (2) step(s);
        s.rst_n = 0; step(s);
        s.rst_n = 1; s.req = 0; step(s);
        // counter saturation and perf_clr priority
        s.req = 1; step(s, 1'b1);
        repeat (4) step(s);
        s.pclr = 1; step(s);
        s.pclr = 0; step(s);
        s.req = 0; s.fclr = 1; step(s);
        s.fclr = 0;
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            s.rst_n = ($urandom_range(0, 199) != 0);
            s.rs1   = 5'($urandom_range(0, 3));
            s.rs2   = 5'($urandom_range(0, 3));
            s.ex_rd = 5'($urandom_range(0, 3));
            s.id_vr = 3'($urandom);
            s.ex_vr = 3'($urandom);
            s.id_mw = 1'($urandom);
            s.ex_mr = 1'($urandom);
            s.redir = ($urandom_range(0, 3) == 0);
            s.req   = ($urandom_range(0, 2) == 0);
            s.ack   = ($urandom_range(0, 2) != 0);
            s.fclr  = ($urandom_range(0, 7) == 0);
            s.pclr  = ($urandom_range(0, 49) == 0);
            step(s);
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV core: the stall/flush side of the operand-bypass network. It detects the hazards that forwarding cannot resolve: load-use dependences, taken branches/jumps, and wait-stated data-memory accesses. For each it drives per-stage hold and bubble controls into the pipeline registers. It also contains a data-memory wait watchdog, a sticky fault flag and a saturating stall-cycle counter.

## Interface
- MAX_WAIT, 15: maximum MEM_WAIT cycles before the watchdog trips. Legal range is 1..255.
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID
- ID_ValidReg  in  3  operand validity for the ID instruction: [0] rd valid, [1] rs1 used, [2] rs2 used
- ID_MemWrite  in  1  the ID instruction is a store
- EX_rd  in  5  destination register of the instruction in EX
- EX_ValidReg  in  3  same encoding as ID_ValidReg, for the EX instruction
- EX_MemRead  in  1  the EX instruction is a load
- EX_redirect  in  1  taken branch or jump resolved in EX
- MEM_req  in  1  the MEM-stage instruction accesses data memory this cycle
- dmem_ack  in  1  data memory completes the access this cycle
- fault_clr  in  1  synchronous clear of FAULT state
- perf_clr  in  1  synchronous clear of stall_count
- PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall  out  1 each  hold the register (no update)
- IF_ID_flush, ID_EX_flush, MEM_WB_flush  out  1 each  load a bubble (valid bits cleared)
- mem_fault  out  1  watchdog tripped (high exactly while in FAULT)
- stall_count  out  32  cycles with PC_stall=1, saturating

## Operation
- **State:** 2-bit FSM with states RUN, MEM_WAIT and FAULT, plus an 8-bit wait_cnt. Stall/flush outputs are Mealy functions of state and current inputs. mem_fault is a function of state only.
- **load_use** (combinational):
  - Requires EX_MemRead & EX_ValidReg[0] & (EX_rd != 0).
  - AND either (ID_ValidReg[1] & ID_rs1 == EX_rd) or (ID_ValidReg[2] & ID_rs2 == EX_rd & !ID_MemWrite).
  - A store's rs2 dependence on a load is resolved by the MEM-side bypass, so it does not stall.
- **freeze** (combinational):
  - In RUN: MEM_req & !dmem_ack.
  - In MEM_WAIT: !dmem_ack.
  - In FAULT: always 1.
- **Output priority, highest first:**
  1. freeze: PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall and MEM_WB_flush = 1. All other outputs 0. Any redirect or load-use is deferred, since EX does not advance.
  2. EX_redirect: IF_ID_flush and ID_EX_flush = 1. load_use is ignored because the ID instruction is killed.
  3. load_use: PC_stall and IF_ID_stall = 1, and ID_EX_flush = 1 (one bubble).
  4. Otherwise all stall/flush outputs are 0.
- **FSM transitions:**
  - RUN → MEM_WAIT when MEM_req & !dmem_ack; wait_cnt <= 1.
  - MEM_WAIT → RUN on dmem_ack. Freeze is already low that cycle, so the pipeline advances; wait_cnt <= 0.
  - MEM_WAIT & !dmem_ack & wait_cnt == MAX_WAIT → FAULT.
  - MEM_WAIT & !dmem_ack otherwise: stay, wait_cnt++.
  - FAULT → RUN only on fault_clr; wait_cnt <= 0. dmem_ack is ignored in FAULT.
- **stall_count:**
  - perf_clr: count <= 0. perf_clr has priority over increment.
  - Else if PC_stall & count != 32'hFFFFFFFF: count++.

## Timing
- **Reset (rst_n low):**
  - state = RUN, wait_cnt = 0, stall_count = 0, mem_fault = 0.
  - All stall/flush outputs are forced 0 asynchronously, independent of inputs.
  - Reset asserted mid-MEM_WAIT or mid-FAULT drops freeze immediately.
- **Zero-wait access:** MEM_req & dmem_ack in the same cycle gives no stall and stays in RUN.
- **Freeze length:** N wait states give exactly N freeze cycles, the first of them Mealy in RUN.
- **Watchdog:** trips after MAX_WAIT+1 consecutive freeze cycles. The FSM enters FAULT on the edge that ends that cycle. mem_fault rises the following cycle and holds until fault_clr.
- **Load-use:** exactly one bubble. On the next cycle the load is in MEM, so the condition clears naturally.
- **Deferred redirect:** a redirect held during freeze asserts its flushes on the first cycle freeze is low.
- **Register x0:** never causes a stall (EX_rd == 0 excluded).

## Test plan
- **Load-use on rs1:** EX lw x5 (EX_MemRead=1, EX_rd=5, EX_ValidReg=3'b001); ID add using rs1=5 (ID_ValidReg=3'b011).
  - Expect PC_stall=IF_ID_stall=ID_EX_flush=1 for 1 cycle, then 0 with EX_MemRead=0.
  - Repeat with EX_rd=0: expect no stall.
- **Store exemption:** ID sw with rs2=5 (ID_ValidReg=3'b100, ID_MemWrite=1) behind the lw x5 → all outputs 0. Same store with rs1=5 → one bubble.
- **Wait states:** MEM_req=1 with dmem_ack low for 3 cycles then high.
  - Expect freeze outputs and MEM_WB_flush high for exactly 3 cycles.
  - Expect RUN after ack and stall_count += 3.
  - Also assert EX_redirect throughout: IF_ID_flush and ID_EX_flush must appear only on the ack cycle.
- **Watchdog:** MAX_WAIT=4, MEM_req=1, dmem_ack=0 forever.
  - Expect mem_fault rising after 5 freeze cycles and staying high through a later dmem_ack.
  - fault_clr → RUN, mem_fault=0, with MEM_req=0 at clear.
- **Priority:** EX_redirect=1 with load_use=1 and MEM_req=0 → IF_ID_flush=ID_EX_flush=1, PC_stall=0.
- **Reset and counter:**
  - rst_n pulsed low for 1 cycle mid-MEM_WAIT (cnt=2) → outputs 0 immediately, state RUN, stall_count=0.
  - Preload stall_count near 2^32-1 via long freeze (or force) → it saturates at 32'hFFFFFFFF.
  - perf_clr together with PC_stall → 0.
